// File: rtl/reflet_bus_arbiter_pkg.sv
// Shared types and constants for the reflet system bus arbiter.
// State encodings, master-count limit and index-width helper.
package reflet_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_ACK   = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_MASTERS = 16;
    localparam int ARB_ID_W        = 4;

    function automatic int arb_index_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reflet_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping at masters-1.
// Fixed priority falls out when 'last' is tied to masters-1.
module reflet_rr_picker
    import reflet_bus_arbiter_pkg::*;
#(
    parameter int masters = 2
) (
    input  logic [masters-1:0]  req,
    input  logic [ARB_ID_W-1:0] last,
    output logic [ARB_ID_W-1:0] winner,
    output logic                found
);

    localparam int IW = arb_index_w(masters);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        // last is always below masters, so one wrap subtraction is enough
        for (int k = 1; k <= masters; k++) begin
            idx = int'(last) + k;
            if (idx >= masters) idx = idx - masters;
            if (!found && req[idx[IW-1:0]]) begin
                found  = 1'b1;
                winner = ARB_ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reflet_bus_arbiter.sv
// Serialises reflet bus transactions from several masters onto one slave bus.
// Define REFLET_ARB_FIXED_PRIORITY_EN for lowest-index-wins instead of round-robin.
module reflet_bus_arbiter
    import reflet_bus_arbiter_pkg::*;
#(
    parameter int wordsize    = 16,
    parameter int masters     = 2,
    parameter int mem_latency = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [masters-1:0]           m_req,
    input  logic [masters*wordsize-1:0]  m_addr,
    input  logic [masters*wordsize-1:0]  m_data_out,
    input  logic [masters-1:0]           m_write_en,
    output logic [wordsize-1:0]          m_data_in,
    output logic [masters-1:0]           m_ack,
    output logic [ARB_ID_W-1:0]          grant_id,
    output logic                         busy,
    output logic [wordsize-1:0]          addr,
    output logic [wordsize-1:0]          data_out,
    output logic                         write_en,
    input  logic [wordsize-1:0]          data_in
);

    localparam int IW = arb_index_w(masters);

    arb_state_t          state;
    logic [3:0]          cnt;
    logic                first;
    logic [ARB_ID_W-1:0] winner;
    logic                found;
    logic [ARB_ID_W-1:0] pick_last;
    logic [IW-1:0]       gidx;
    logic [masters-1:0]  ack_onehot;

`ifdef REFLET_ARB_FIXED_PRIORITY_EN
    assign pick_last = ARB_ID_W'(masters - 1);
`else
    logic [ARB_ID_W-1:0] last;
    assign pick_last = last;
`endif

    reflet_rr_picker #(.masters(masters)) u_picker (
        .req    (m_req),
        .last   (pick_last),
        .winner (winner),
        .found  (found)
    );

    assign gidx = grant_id[IW-1:0];
    assign busy = (state != ARB_IDLE);

    always_comb begin
        ack_onehot       = '0;
        ack_onehot[gidx] = 1'b1;
    end

    // The write strobe is offered once; a stall in the first cycle defers it rather than repeating it.
    always_comb begin
        addr     = '0;
        data_out = '0;
        write_en = 1'b0;
        if (state == ARB_ISSUE) begin
            addr     = m_addr[gidx*wordsize +: wordsize];
            data_out = m_data_out[gidx*wordsize +: wordsize];
            write_en = first && enable && m_write_en[gidx];
        end
    end

    // cnt starts at mem_latency so data_in is sampled mem_latency cycles after the first address cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            m_ack     <= '0;
            m_data_in <= '0;
            grant_id  <= '0;
            cnt       <= '0;
            first     <= 1'b0;
`ifndef REFLET_ARB_FIXED_PRIORITY_EN
            last      <= ARB_ID_W'(masters - 1);
`endif
        end else begin
            m_ack <= '0;
            if (enable) begin
                case (state)
                    ARB_IDLE: begin
                        if (found) begin
                            grant_id <= winner;
`ifndef REFLET_ARB_FIXED_PRIORITY_EN
                            last     <= winner;
`endif
                            cnt      <= 4'(mem_latency);
                            first    <= 1'b1;
                            state    <= ARB_ISSUE;
                        end
                    end
                    ARB_ISSUE: begin
                        first <= 1'b0;
                        if (cnt == 4'd0) begin
                            m_data_in <= data_in;
                            m_ack     <= ack_onehot;
                            state     <= ARB_ACK;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    ARB_ACK:  state <= ARB_IDLE;
                    default:  state <= ARB_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Directed bench for reflet_bus_arbiter: a 2-master/latency-1 instance and a 4-master/latency-3 instance.
module tb_reflet_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  a_req, a_we, a_ack;
    logic [31:0] a_maddr, a_mdout;
    logic [15:0] a_mdin, a_addr, a_dout, a_din;
    logic [3:0]  a_gid;
    logic        a_busy, a_wen;

    logic [3:0]  b_req, b_we, b_ack;
    logic [63:0] b_maddr, b_mdout;
    logic [15:0] b_mdin, b_addr, b_dout, b_din;
    logic [3:0]  b_gid;
    logic        b_busy, b_wen;

    int vectors = 0;
    int miscompares = 0;

    reflet_bus_arbiter #(.wordsize(16), .masters(2), .mem_latency(1)) u_a (
        .clk(clk), .reset(reset), .enable(enable),
        .m_req(a_req), .m_addr(a_maddr), .m_data_out(a_mdout), .m_write_en(a_we),
        .m_data_in(a_mdin), .m_ack(a_ack), .grant_id(a_gid), .busy(a_busy),
        .addr(a_addr), .data_out(a_dout), .write_en(a_wen), .data_in(a_din)
    );

    reflet_bus_arbiter #(.wordsize(16), .masters(4), .mem_latency(3)) u_b (
        .clk(clk), .reset(reset), .enable(enable),
        .m_req(b_req), .m_addr(b_maddr), .m_data_out(b_mdout), .m_write_en(b_we),
        .m_data_in(b_mdin), .m_ack(b_ack), .grant_id(b_gid), .busy(b_busy),
        .addr(b_addr), .data_out(b_dout), .write_en(b_wen), .data_in(b_din)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; enable = 1'b1;
        a_req = '0; a_we = '0; a_maddr = '0; a_mdout = '0; a_din = '0;
        b_req = '0; b_we = '0; b_maddr = '0; b_mdout = '0; b_din = '0;
        tick; tick;
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        vectors++; if (a_ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack: got %b want 00", a_ack); end
        vectors++; if (a_gid !== 4'd0) begin miscompares++; $display("FAIL reset_gid: got %0d want 0", a_gid); end
        vectors++; if (a_mdin !== 16'h0) begin miscompares++; $display("FAIL reset_mdin: got %h want 0000", a_mdin); end
        vectors++; if (a_addr !== 16'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0000", a_addr); end
        vectors++; if (a_wen !== 1'b0) begin miscompares++; $display("FAIL reset_wen: got %b want 0", a_wen); end
        vectors++; if (b_busy !== 1'b0) begin miscompares++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_single_read;
        a_maddr[15:0] = 16'h0010; a_we = 2'b00; a_din = 16'hBEEF; a_req = 2'b01;
        tick;
        vectors++; if (a_addr !== 16'h0010) begin miscompares++; $display("FAIL read_addr: got %h want 0010", a_addr); end
        vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("FAIL read_busy: got %b want 1", a_busy); end
        vectors++; if (a_wen !== 1'b0) begin miscompares++; $display("FAIL read_wen: got %b want 0", a_wen); end
        tick;
        vectors++; if (a_ack !== 2'b00) begin miscompares++; $display("FAIL read_early_ack: got %b want 00", a_ack); end
        tick;
        vectors++; if (a_ack !== 2'b01) begin miscompares++; $display("FAIL read_ack: got %b want 01", a_ack); end
        vectors++; if (a_mdin !== 16'hBEEF) begin miscompares++; $display("FAIL read_data: got %h want beef", a_mdin); end
        a_req = 2'b00; a_din = 16'h0000;
        tick;
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL read_idle: got %b want 0", a_busy); end
        vectors++; if (a_mdin !== 16'hBEEF) begin miscompares++; $display("FAIL read_hold: got %h want beef", a_mdin); end
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp_gid;
        logic [1:0] ack_val;
        int ack_cyc;
`ifdef REFLET_ARB_FIXED_PRIORITY_EN
        exp_gid = 4'd0;
`else
        exp_gid = 4'd1;
`endif
        a_maddr = {16'h0111, 16'h0100}; a_we = 2'b00; a_req = 2'b11;
        tick;
        vectors++; if (a_gid !== exp_gid) begin miscompares++; $display("FAIL rmid_pre_gid: got %0d want %0d", a_gid, exp_gid); end
        vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_busy: got %b want 1", a_busy); end
        reset = 1'b0;
        tick;
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", a_busy); end
        vectors++; if (a_ack !== 2'b00) begin miscompares++; $display("FAIL rmid_ack: got %b want 00", a_ack); end
        vectors++; if (a_addr !== 16'h0) begin miscompares++; $display("FAIL rmid_addr: got %h want 0000", a_addr); end
        reset = 1'b1;
        tick;
        vectors++; if (a_gid !== 4'd0) begin miscompares++; $display("FAIL rmid_regrant: got %0d want 0", a_gid); end
        vectors++; if (a_addr !== 16'h0100) begin miscompares++; $display("FAIL rmid_regrant_addr: got %h want 0100", a_addr); end
        a_req = 2'b00;
        ack_cyc = -1; ack_val = '0;
        for (int c = 4; c <= 8; c++) begin
            tick;
            if (a_ack !== 2'b00 && ack_cyc < 0) begin ack_cyc = c; ack_val = a_ack; end
        end
        vectors++; if (ack_cyc != 5) begin miscompares++; $display("FAIL rmid_drop_ack_cycle: got %0d want 5", ack_cyc); end
        vectors++; if (ack_val !== 2'b01) begin miscompares++; $display("FAIL rmid_drop_ack_val: got %b want 01", ack_val); end
    endtask

    task automatic test_round_robin;
        int got;
        int exp;
        logic [1:0] exp_ack;
        reset = 1'b0; tick; reset = 1'b1;
        a_maddr = {16'h0222, 16'h0200}; a_we = 2'b00; a_req = 2'b11;
        got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            tick;
            if (a_ack !== 2'b00) begin
`ifdef REFLET_ARB_FIXED_PRIORITY_EN
                exp = 0;
`else
                exp = got % 2;
`endif
                exp_ack = (exp == 0) ? 2'b01 : 2'b10;
                vectors++; if ($countones(a_ack) != 1) begin miscompares++; $display("FAIL rr_onehot_%0d: got %b want one-hot", got, a_ack); end
                vectors++; if (a_ack !== exp_ack) begin miscompares++; $display("FAIL rr_ack_%0d: got %b want %b", got, a_ack, exp_ack); end
                vectors++; if (a_gid !== 4'(exp)) begin miscompares++; $display("FAIL rr_gid_%0d: got %0d want %0d", got, a_gid, exp); end
                got++;
            end
        end
        vectors++; if (got != 6) begin miscompares++; $display("FAIL rr_timeout: got %0d acks want 6", got); end
        a_req = 2'b00;
        tick; tick;
    endtask

    task automatic test_write_latency;
        int we_cnt, we_cyc, ack_cyc;
        logic [15:0] dout_w, addr_w;
        logic [3:0] ack_val;
        b_maddr[31:16] = 16'h0020; b_mdout[31:16] = 16'h1234; b_we = 4'b0010; b_req = 4'b0010;
        we_cnt = 0; we_cyc = -1; ack_cyc = -1; dout_w = '0; addr_w = '0; ack_val = '0;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (b_wen) begin we_cnt++; we_cyc = c; dout_w = b_dout; addr_w = b_addr; end
            if (b_ack !== 4'b0000 && ack_cyc < 0) begin ack_cyc = c; ack_val = b_ack; b_req = 4'b0000; b_we = 4'b0000; end
        end
        vectors++; if (we_cnt != 1) begin miscompares++; $display("FAIL wr_we_count: got %0d want 1", we_cnt); end
        vectors++; if (we_cyc != 1) begin miscompares++; $display("FAIL wr_we_cycle: got %0d want 1", we_cyc); end
        vectors++; if (dout_w !== 16'h1234) begin miscompares++; $display("FAIL wr_data: got %h want 1234", dout_w); end
        vectors++; if (addr_w !== 16'h0020) begin miscompares++; $display("FAIL wr_addr: got %h want 0020", addr_w); end
        vectors++; if (ack_cyc != 5) begin miscompares++; $display("FAIL wr_ack_cycle: got %0d want 5", ack_cyc); end
        vectors++; if (ack_val !== 4'b0010) begin miscompares++; $display("FAIL wr_ack_val: got %b want 0010", ack_val); end
    endtask

    task automatic test_enable_stall;
        int we_cnt, we_cyc, ack_cyc;
        logic [3:0] ack_val;
        logic busy_mid;
        b_maddr[47:32] = 16'h0030; b_mdout[47:32] = 16'h5678; b_we = 4'b0100; b_req = 4'b0100;
        we_cnt = 0; we_cyc = -1; ack_cyc = -1; ack_val = '0; busy_mid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            enable = !(c >= 2 && c <= 5);
            #1;
            if (c == 4) busy_mid = b_busy;
            if (b_wen) begin we_cnt++; we_cyc = c; end
            if (b_ack !== 4'b0000 && ack_cyc < 0) begin ack_cyc = c; ack_val = b_ack; b_req = 4'b0000; b_we = 4'b0000; end
        end
        enable = 1'b1;
        vectors++; if (we_cnt != 1) begin miscompares++; $display("FAIL stall_we_count: got %0d want 1", we_cnt); end
        vectors++; if (we_cyc != 1) begin miscompares++; $display("FAIL stall_we_cycle: got %0d want 1", we_cyc); end
        vectors++; if (busy_mid !== 1'b1) begin miscompares++; $display("FAIL stall_busy: got %b want 1", busy_mid); end
        vectors++; if (ack_cyc != 9) begin miscompares++; $display("FAIL stall_ack_cycle: got %0d want 9", ack_cyc); end
        vectors++; if (ack_val !== 4'b0100) begin miscompares++; $display("FAIL stall_ack_val: got %b want 0100", ack_val); end
    endtask

    task automatic test_wrap;
        int ack_cyc;
        logic [3:0] ack_val, gid_at;
        reset = 1'b0; tick; reset = 1'b1;
        b_maddr[63:48] = 16'h0040; b_maddr[15:0] = 16'h0041; b_we = 4'b0000; b_req = 4'b1000;
        ack_cyc = -1; ack_val = '0; gid_at = '0;
        for (int c = 1; c <= 10 && ack_cyc < 0; c++) begin
            tick;
            if (b_ack !== 4'b0000) begin ack_cyc = c; ack_val = b_ack; gid_at = b_gid; b_req = 4'b1001; end
        end
        vectors++; if (ack_cyc != 5) begin miscompares++; $display("FAIL wrap_ack_cycle: got %0d want 5", ack_cyc); end
        vectors++; if (ack_val !== 4'b1000) begin miscompares++; $display("FAIL wrap_ack_val: got %b want 1000", ack_val); end
        vectors++; if (gid_at !== 4'd3) begin miscompares++; $display("FAIL wrap_gid3: got %0d want 3", gid_at); end
        tick; tick;
        vectors++; if (b_gid !== 4'd0) begin miscompares++; $display("FAIL wrap_gid0: got %0d want 0", b_gid); end
        vectors++; if (b_addr !== 16'h0041) begin miscompares++; $display("FAIL wrap_addr: got %h want 0041", b_addr); end
        b_req = 4'b0000;
        for (int c = 0; c < 8; c++) tick;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_reset_mid;
        test_round_robin;
        test_write_latency;
        test_enable_stall;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
